// File: rtl/train_scheduler.sv
// Epoch/sample sequencer for the bias-weight update datapath: gates Delta1, drains in-flight
// updates at epoch boundaries, then runs a test pass. Define LR_DECAY_EN to halve oLR per epoch.
module train_scheduler #(
  parameter int unsigned WF         = 8,
  parameter int unsigned NS         = 16,
  parameter int unsigned NE         = 8,
  parameter int unsigned NF         = 4,
  parameter int unsigned LR_MIN     = 1,
  parameter logic        MODE_TRAIN = 1'b0,
  parameter logic        MODE_TEST  = 1'b1
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iStart,
  input  logic [NE-1:0] iEpochs,
  input  logic [NS-1:0] iSamples,
  input  logic [WF-1:0] iLR0,
  input  logic          iValid_Delta,
  input  logic          iReady_Delta,
  input  logic          iValid_State,
  input  logic          iReady_State,
  input  logic          iValid_Weight,
  input  logic          iReady_Weight,
  output logic          oMode,
  output logic [WF-1:0] oLR,
  output logic          oGate,
  output logic [NE-1:0] oEpoch,
  output logic          oBusy,
  output logic          oDone,
  output logic          oErr
);

  typedef enum logic [2:0] {StIdle, StTrain, StDrain, StTest, StDone} state_e;

  state_e        state_q;
  logic [NS-1:0] samples_q;
  logic [NS-1:0] sample_cnt_q;
  logic [NE-1:0] epochs_q;
  logic [NF-1:0] inflight_q;
  logic [WF-1:0] lr_decay;

  logic dacc, wacc, sacc;
  logic start_acc, inflight_zero, inflight_full, err_ev;
  logic last_sample, last_epoch;

  assign oGate = (state_q == StTrain);
  assign oMode = (state_q == StTrain || state_q == StDrain) ? MODE_TRAIN : MODE_TEST;
  assign oBusy = (state_q == StTrain || state_q == StDrain || state_q == StTest);
  assign oDone = (state_q == StDone);

  assign dacc = iValid_Delta & iReady_Delta & oGate;
  assign wacc = iValid_Weight & iReady_Weight;
  assign sacc = iValid_State & iReady_State;

  assign start_acc     = iStart & (state_q == StIdle || state_q == StDone);
  assign inflight_zero = (inflight_q == '0);
  assign inflight_full = &inflight_q;
  // Underflow or overflow of the in-flight tracker means the handshake monitors disagree.
  assign err_ev        = (wacc & ~dacc & inflight_zero) | (dacc & ~wacc & inflight_full);
  assign last_sample   = ((sample_cnt_q + NS'(1)) == samples_q);
  assign last_epoch    = ((oEpoch + NE'(1)) == epochs_q);

`ifdef LR_DECAY_EN
  localparam logic [WF-1:0] LrMin = WF'(LR_MIN);

  always_comb begin
    lr_decay = oLR;
    if (oLR >= LrMin) begin
      lr_decay = ((oLR >> 1) > LrMin) ? (oLR >> 1) : LrMin;
    end
  end
`else
  assign lr_decay = oLR;
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      inflight_q <= '0;
      oErr       <= 1'b0;
    end else begin
      if (dacc && !wacc && !inflight_full) begin
        inflight_q <= inflight_q + NF'(1);
      end else if (wacc && !dacc && !inflight_zero) begin
        inflight_q <= inflight_q - NF'(1);
      end
      if (err_ev) begin
        oErr <= 1'b1;
      end else if (start_acc) begin
        oErr <= 1'b0;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q      <= StIdle;
      samples_q    <= '0;
      epochs_q     <= '0;
      sample_cnt_q <= '0;
      oLR          <= '0;
      oEpoch       <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (iStart) begin
            epochs_q     <= iEpochs;
            samples_q    <= iSamples;
            oLR          <= iLR0;
            sample_cnt_q <= '0;
            oEpoch       <= '0;
            state_q      <= (iEpochs == '0) ? StTest : StTrain;
          end
        end
        StTrain: begin
          if (samples_q == '0) begin
            state_q <= StDrain;
          end else if (dacc) begin
            sample_cnt_q <= sample_cnt_q + NS'(1);
            if (last_sample) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (inflight_zero) begin
            oEpoch       <= oEpoch + NE'(1);
            sample_cnt_q <= '0;
            oLR          <= lr_decay;
            state_q      <= last_epoch ? StTest : StTrain;
          end
        end
        StTest: begin
          if (samples_q == '0) begin
            state_q <= StDone;
          end else if (sacc) begin
            sample_cnt_q <= sample_cnt_q + NS'(1);
            if (last_sample) state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/train_scheduler.md
# train_scheduler

Sequencer for the bias/weight update datapath. It drives the mode and learning-rate inputs, counts training samples per epoch, and gates Delta1 transfers at epoch boundaries. Before any mode or LR change it waits for all in-flight updates to drain. It then runs a test pass and signals completion. It sits between the host/control interface and the layer's bias-weight update block.

## Interface
- WF, 8, fixed-point word width of the learning rate
- NS, 16, sample-counter width
- NE, 8, epoch-counter width
- NF, 4, in-flight counter width (must exceed the update pipeline depth)
- LR_MIN, 1, lower bound for the decayed learning rate (unsigned)

Ports:
- iCLK  in  1  clock; everything is on the rising edge
- iRST  in  1  synchronous, active-high reset
- iStart  in  1  start pulse; accepted only in IDLE or DONE
- iEpochs  in  NE  number of training epochs, latched on start
- iSamples  in  NS  samples per epoch and per test pass, latched on start
- iLR0  in  WF  initial learning rate, latched on start
- iValid_Delta, iReady_Delta  in  1  monitor of the Delta1 handshake after gating
- iValid_State, iReady_State  in  1  monitor of the State1 handshake (used in the test pass)
- iValid_Weight, iReady_Weight  in  1  monitor of the weight-output handshake (update completion)
- oMode  out  1  TRAIN/TEST encoding from Parameter.vh mode parameters
- oLR  out  WF  learning rate to the datapath
- oGate  out  1  ANDed externally into the Delta1 valid and ready
- oEpoch  out  NE  completed-epoch count
- oBusy, oDone, oErr  out  1  status flags

## Operation
- States: IDLE, TRAIN, DRAIN, TEST, DONE.
- The state register is registered. oGate is decoded from it: oGate = (state == TRAIN).
- Events:
  - dacc = iValid_Delta & iReady_Delta & oGate
  - wacc = iValid_Weight & iReady_Weight
  - sacc = iValid_State & iReady_State
- In-flight counter:
  - +1 on dacc, −1 on wacc; unchanged when both occur in the same cycle.
  - Decrement at 0 sets oErr (sticky) and holds the counter at 0.
  - Increment at all-ones sets oErr and saturates.
- IDLE/DONE + iStart:
  - Latch iEpochs, iSamples and iLR0; set oLR = iLR0.
  - Clear the sample count, epoch count, oDone and oErr.
  - Go to TRAIN, or to TEST if iEpochs == 0.
- TRAIN:
  - The sample count increments on dacc.
  - When dacc brings the count to iSamples, go to DRAIN.
  - If iSamples == 0, go to DRAIN on the next edge without any transfer.
- DRAIN (gate low):
  - Wait until the in-flight count is 0.
  - Then: epoch count +1; clear the sample count; update oLR.
  - If the new epoch count == iEpochs, go to TEST, else go to TRAIN.
- TEST:
  - oMode = TEST, oGate = 0.
  - Count sacc; after iSamples accepts (or immediately if iSamples == 0), go to DONE.
- DONE: oDone = 1, oMode = TEST; hold until iStart or reset.
- oMode = TRAIN only in TRAIN and DRAIN.
- oBusy = 1 in TRAIN, DRAIN and TEST.
- oLR update (unsigned): oLR ← max(oLR >> 1, LR_MIN). If oLR is already < LR_MIN, it is left unchanged.
- iStart outside IDLE/DONE is ignored.
- Reset mid-operation returns to IDLE immediately. The in-flight count clears and handshakes still in the datapath are not tracked.

## Timing
- Reset values:
  - state = IDLE
  - oMode = TEST, oLR = 0, oGate = 0, oEpoch = 0
  - oBusy = 0, oDone = 0, oErr = 0
  - all counters 0
- iStart at edge t: TRAIN, oMode = TRAIN, oLR = iLR0 and oGate = 1 are all visible after edge t.
- Epoch end: the last dacc is at edge t. DRAIN and oGate = 0 from edge t. No further dacc is possible.
- Drain exit: the in-flight count reads 0 before edge t. oEpoch, oLR and the next state update at edge t.
- Minimum DRAIN dwell is 1 cycle.
- wacc on the same edge as the last dacc is counted correctly (net 0).
- TEST to DONE: at the edge of the final sacc.

## Configuration
- LR_DECAY_EN defined: oLR is decayed at every epoch boundary as described above.
- LR_DECAY_EN undefined: oLR stays at iLR0 for the whole run. LR_MIN is unused and the shifter logic is removed.
- All other behaviour is identical with or without the macro.

## Test plan
- iEpochs = 2, iSamples = 3, iLR0 = 0x40, pipeline latency 2, LR_DECAY_EN on:
  - 3 gated dacc, DRAIN waits for 3 wacc, oEpoch = 1, oLR = 0x20.
  - Second epoch, then oEpoch = 2, oLR = 0x10, then TEST.
  - 3 sacc, then oDone = 1.
- Same stimulus with LR_DECAY_EN off: oLR = 0x40 throughout; otherwise identical.
- iLR0 = 0x03, LR_MIN = 2, 3 epochs, decay on: oLR sequence 0x03 → 0x02 → 0x02 → 0x02.
- iEpochs = 0, iSamples = 0: TEST for one cycle, then DONE, with oGate never high.
- Simultaneous dacc and wacc each cycle: in-flight count stays constant.
- A wacc with in-flight count 0 sets oErr and the count stays 0.
- iRST asserted in DRAIN with in-flight count 2:
  - Next cycle: IDLE, all outputs at reset values.
  - A subsequent iStart runs cleanly.
